piccolo_block_feeder: RTL and testbench

Upstream/downstream sequencing stage for the unrolled Piccolo-128 encryption core. It assembles a 64-bit plaintext block from two 32-bit bus words and pulses the core's active-high load input for one cycle. After a fixed core latency it captures the core's combinational ciphertext and holds it for the consumer under a valid/ready handshake. The core instance sits beside this block at the top level, not inside it.

---
 rtl/piccolo_pkg.sv | 17 +
 rtl/piccolo_block_feeder.sv | 97 +++++++++
 tb/tb_piccolo_block_feeder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/piccolo_pkg.sv
// Shared definitions for the Piccolo-128 block feeder: widths, default core
// latency and the feeder FSM state encoding.
package piccolo_pkg;

    localparam int unsigned PICCOLO_BLK_W    = 64;
    localparam int unsigned PICCOLO_WORD_W   = 32;
    localparam int unsigned PICCOLO_CORE_LAT = 2;

    typedef enum logic [2:0] {
        S_FILL0,
        S_FILL1,
        S_LOAD,
        S_WAIT,
        S_HOLD
    } feeder_state_t;

endpackage

// File: rtl/piccolo_block_feeder.sv
// Assembles a 64-bit plaintext from two bus words, pulses the core load, waits
// a fixed core latency, then holds the captured ciphertext under valid/ready.
module piccolo_block_feeder
    import piccolo_pkg::*;
#(
    parameter int unsigned CORE_LAT = PICCOLO_CORE_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:PICCOLO_WORD_W-1] in_data,
    output logic                      core_load,
    output logic [0:PICCOLO_BLK_W-1]  core_plaintext,
    input  logic [0:PICCOLO_BLK_W-1]  core_ciphertext,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [0:PICCOLO_BLK_W-1]  out_data,
    output logic                      busy
);

    localparam logic [3:0] CNT_INIT = 4'(CORE_LAT - 1);

    feeder_state_t state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic          take_hi, take_lo, capture;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_FILL0;
            cnt            <= '0;
            core_plaintext <= '0;
            out_data       <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (take_hi)
                core_plaintext[0:PICCOLO_WORD_W-1] <= in_data;
            if (take_lo)
                core_plaintext[PICCOLO_WORD_W:PICCOLO_BLK_W-1] <= in_data;
            if (capture)
                out_data <= core_ciphertext;
        end
    end

    // Handshake outputs decode from state only; in_valid/out_ready only steer
    // the next state and the data enables.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        capture    = 1'b0;
        in_ready   = 1'b0;
        core_load  = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_FILL0: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    take_hi    = 1'b1;
                    state_next = S_FILL1;
                end
            end
            S_FILL1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    take_lo    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                core_load  = 1'b1;
                busy       = 1'b1;
                cnt_next   = CNT_INIT;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = S_FILL0;
            end
            default: state_next = S_FILL0;
        endcase
    end

endmodule

// File: tb/tb_piccolo_block_feeder.sv
// Scoreboard bench for piccolo_block_feeder with a stub core (ciphertext =
// ~plaintext); extra instances at CORE_LAT 1 and 15 cover the latency sweep.
module tb_piccolo_block_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [0:31] in_data;
    logic        out_ready;

    logic        in_ready, core_load, out_valid, busy;
    logic [0:63] core_plaintext, core_ciphertext, out_data;
    logic        in_ready1, core_load1, out_valid1, busy1;
    logic [0:63] pt1, ct1, od1;
    logic        in_ready15, core_load15, out_valid15, busy15;
    logic [0:63] pt15, ct15, od15;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign core_ciphertext = ~core_plaintext;
    assign ct1             = ~pt1;
    assign ct15            = ~pt15;

    piccolo_block_feeder #(.CORE_LAT(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .core_load(core_load), .core_plaintext(core_plaintext),
        .core_ciphertext(core_ciphertext), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    piccolo_block_feeder #(.CORE_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .core_load(core_load1), .core_plaintext(pt1),
        .core_ciphertext(ct1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(od1), .busy(busy1)
    );

    piccolo_block_feeder #(.CORE_LAT(15)) u_dut_lat15 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready15),
        .in_data(in_data), .core_load(core_load15), .core_plaintext(pt15),
        .core_ciphertext(ct15), .out_valid(out_valid15),
        .out_ready(out_ready), .out_data(od15), .busy(busy15)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle out_valid is high, out_data must equal the oldest
    // expected block; a handshake retires it.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_data %h, required no output (cycle %0d)",
                         out_data, cyc);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Drives one word and returns the cycle in which it was accepted.
    task automatic put_word(input logic [31:0] w, output int acc);
        acc      = -1;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) acc = cyc;
            @(posedge clk);
            #1;
            if (acc >= 0) break;
        end
        in_valid = 1'b0;
        if (acc < 0) chk("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_ov(output int c);
        c = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) begin
                c = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (c < 0) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_core_load"}, 64'(core_load), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_out_data"},  out_data,       64'd0);
        chk({tag, "_plaintext"}, core_plaintext, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, r0, r1, r15, nload, lcyc, hs, acc;
        logic [31:0] w0, w1;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Stub core, back-to-back words, plus the latency sweep instances.
        out_ready = 1'b1;
        exp_q.push_back(64'hfedcba9876543210);
        put_word(32'h01234567, t0);
        put_word(32'h89abcdef, t1);
        chk("word1_cycle", 64'(t1), 64'(t0 + 1));
        r0 = -1; r1 = -1; r15 = -1; nload = 0; lcyc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (core_load) begin
                nload++;
                lcyc = cyc;
            end
            if (out_valid && r0 < 0) r0 = cyc;
            if (out_valid1 && r1 < 0) begin
                r1 = cyc;
                chk("lat1_out_data", od1, 64'hfedcba9876543210);
            end
            if (out_valid15 && r15 < 0) begin
                r15 = cyc;
                chk("lat15_out_data", od15, 64'hfedcba9876543210);
            end
            if (r0 >= 0 && r1 >= 0 && r15 >= 0 && cyc > t0 + 20) break;
        end
        @(posedge clk);
        #1;
        chk("load_count", 64'(nload), 64'd1);
        chk("load_cycle", 64'(lcyc), 64'(t0 + 2));
        chk("valid_cycle_lat2", 64'(r0), 64'(t0 + 5));
        chk("valid_cycle_lat1", 64'(r1), 64'(t0 + 4));
        chk("valid_cycle_lat15", 64'(r15), 64'(t0 + 18));

        // Throughput with an always-ready consumer: 6 cycles per block.
        exp_q.push_back(64'hfedcba9876543210);
        exp_q.push_back(64'h0123456789abcdef);
        put_word(32'h01234567, t0);
        put_word(32'h89abcdef, t1);
        wait_ov(r0);
        put_word(32'hfedcba98, t0);
        chk("next_accept_after_hs", 64'(t0), 64'(r0 + 1));
        put_word(32'h76543210, t1);
        wait_ov(r1);
        chk("throughput", 64'(r1), 64'(r0 + 6));

        // Backpressure: 20 stalled cycles with new words offered.
        out_ready = 1'b0;
        exp_q.push_back(64'h21524110ffffffff);
        exp_q.push_back(64'heca86420db97531f);
        put_word(32'hdeadbeef, t0);
        put_word(32'h00000000, t1);
        wait_ov(r0);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_data = 32'h1000_0000 + 32'(n);
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_plaintext", core_plaintext, 64'hdeadbeef00000000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        hs = cyc;
        put_word(32'h13579bdf, acc);
        chk("accept_after_stall", 64'(acc), 64'(hs + 1));
        put_word(32'h2468ace0, t1);
        wait_ov(r0);

        // Gapped input: three idle cycles between the two words.
        exp_q.push_back(64'h00000000f0f0f0f0);
        put_word(32'hffffffff, t0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("gap_in_ready", 64'(in_ready), 64'd1);
            chk("gap_no_load", 64'({core_load, busy}), 64'd0);
            @(posedge clk);
            #1;
        end
        put_word(32'h0f0f0f0f, t1);
        chk("gap_word1_cycle", 64'(t1), 64'(t0 + 4));
        @(negedge clk);
        chk("gap_load_next_cycle", 64'(core_load), 64'd1);
        @(posedge clk);
        #1;
        wait_ov(r0);
        chk("gap_valid_cycle", 64'(r0), 64'(t1 + 4));

        // Reset while in WAIT discards the block.
        put_word(32'haaaaaaaa, t0);
        put_word(32'h55555555, t1);
        @(negedge clk);
        chk("abort_load", 64'(core_load), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_wait", 64'({busy, core_load}), 64'b10);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_values("abort");
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("abort_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(64'hfffffffe7fffffff);
        put_word(32'h00000001, t0);
        put_word(32'h80000000, t1);
        wait_ov(r0);
        chk("fresh_valid_cycle", 64'(r0), 64'(t0 + 5));

        // A few more blocks with bench-computed expectations.
        for (int b = 0; b < 6; b++) begin
            w0 = $urandom;
            w1 = $urandom;
            exp_q.push_back(~{w0, w1});
            put_word(w0, t0);
            put_word(w1, t1);
        end

        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
